// File: rtl/spi_cfg_controller.sv
// Round-robin arbitrated SPI write master: 16-bit mode-0 frames {1'b1, addr[6:0], data[7:0]}, MSB first.
// Optional feature macro: SPI_CFG_ADDR_CHECK_EN (drop writes above 7'h04 with an err pulse).
module spi_cfg_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       done,
  output logic       grant_id,
  output logic       err
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

  if (CLK_DIV < 2 || CS_GAP < 2) begin : g_param_check
    $error("spi_cfg_controller: CLK_DIV and CS_GAP must both be >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [3:0]      bit_r, bit_s;
  logic [15:0]     frame_r, frame_s;
  logic            ptr_r, ptr_s;
  logic            grant_r, grant_s;
  logic            ncs_r, sclk_r, copi_r, busy_r, done_r, err_r;
  logic            ncs_s, sclk_s, copi_s, busy_s, done_s, err_s;
  logic            any_valid_s, sel_s, accept_s, bad_addr_s;
  logic [6:0]      acc_addr_s;
  logic [7:0]      acc_data_s;

  // Arbiter: a lone requester wins, a tie goes to the priority pointer.
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    sel_s       = (req0_valid && req1_valid) ? ptr_r : req1_valid;
    accept_s    = (state_r == ST_IDLE) && any_valid_s;
    acc_addr_s  = sel_s ? req1_addr : req0_addr;
    acc_data_s  = sel_s ? req1_data : req0_data;
`ifdef SPI_CFG_ADDR_CHECK_EN
    bad_addr_s  = (acc_addr_s > 7'h04);
`else
    bad_addr_s  = 1'b0;
`endif
  end

  assign req0_ready = rst_n & accept_s & ~sel_s;
  assign req1_ready = rst_n & accept_s & sel_s;

  // Next-state logic: every timed phase counts cnt_r from 0 to its last cycle.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    bit_s   = bit_r;
    frame_s = frame_r;
    ptr_s   = ptr_r;
    grant_s = grant_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (accept_s) begin
          ptr_s   = ~sel_s;
          grant_s = sel_s;
          frame_s = {1'b1, acc_addr_s, acc_data_s};
          bit_s   = 4'd15;
          state_s = bad_addr_s ? ST_IDLE : ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (cnt_r == DIV_LAST) begin
          state_s = ST_HIGH;
          cnt_s   = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_HIGH: begin
        if (cnt_r == DIV_LAST) begin
          cnt_s = '0;
          if (bit_r == 4'd0) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_LOW;
            bit_s   = bit_r - 4'd1;
          end
        end else begin
          state_s = ST_HIGH;
        end
      end
      ST_HOLD: begin
        if (cnt_r == DIV_LAST) begin
          state_s = ST_GAP;
          cnt_s   = '0;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state.
  always_comb begin
    ncs_s  = 1'b1;
    sclk_s = 1'b0;
    copi_s = 1'b0;
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_GAP) && (state_r != ST_GAP);
    err_s  = accept_s & bad_addr_s;
    case (state_s)
      ST_SETUP, ST_LOW: begin
        ncs_s  = 1'b0;
        copi_s = frame_s[bit_s];
      end
      ST_HIGH: begin
        ncs_s  = 1'b0;
        sclk_s = 1'b1;
        copi_s = frame_s[bit_s];
      end
      ST_HOLD: ncs_s = 1'b0;
      default: ncs_s = 1'b1;
    endcase
  end

  // State, counters, latched frame and arbiter pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      bit_r   <= 4'd0;
      frame_r <= 16'h0000;
      ptr_r   <= 1'b0;
      grant_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      frame_r <= frame_s;
      ptr_r   <= ptr_s;
      grant_r <= grant_s;
    end
  end

  // Registered SPI pins and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_r  <= 1'b1;
      sclk_r <= 1'b0;
      copi_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      ncs_r  <= ncs_s;
      sclk_r <= sclk_s;
      copi_r <= copi_s;
      busy_r <= busy_s;
      done_r <= done_s;
      err_r  <= err_s;
    end
  end

  assign nCS      = ncs_r;
  assign SCLK     = sclk_r;
  assign COPI     = copi_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign grant_id = grant_r;
  assign err      = err_r;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Self-checking bench for spi_cfg_controller: timeline model derived from accept cycles, random traffic plus directed cases.
`timescale 1ns/1ps
module tb_spi_cfg_controller;

  localparam int CD     = 4;
  localparam int GAP    = 4;
  localparam int LOWLEN = 33 * CD;
  localparam int PERIOD = 1 + LOWLEN + GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [6:0] req0_addr = 7'h00, req1_addr = 7'h00;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       nCS, SCLK, COPI, busy, done, grant_id, err;

  spi_cfg_controller #(.CLK_DIV(CD), .CS_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .nCS(nCS), .SCLK(SCLK), .COPI(COPI), .busy(busy), .done(done), .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Requester queues of {addr, data} and issue probabilities.
  logic [14:0] q0[$], q1[$];
  int p0 = 100, p1 = 100;
  bit acc0 = 0, acc1 = 0;

  // Behavioural model state.
  int          cyc = 0;
  int          free_at = 0;
  bit          m_ptr = 0, m_grant = 0, m_active = 0;
  int          m_t0 = 0, m_err_at = -1;
  logic [15:0] m_frame = 16'h0000;

  // Measurements for directed literal checks.
  int          acc_cyc[$];
  bit          acc_id[$];
  int          meas_low = 0, meas_done = -1, meas_acc = 0;
  logic [15:0] meas_bits = 16'h0000;
  logic        sclk_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL timeout %s: got no completion expected completion (cycle %0d)", name, cyc);
  endtask

  // Expected pins d cycles after an accept: frame phases of CD cycles, odd phases have SCLK high.
  function automatic void exp_out(input int d, input logic [15:0] f, output logic ncs, output logic sclk,
                                  output logic copi, output logic copi_vld, output logic bsy, output logic dn);
    int j;
    ncs = 1'b1; sclk = 1'b0; copi = 1'b0; copi_vld = 1'b0;
    bsy = (d >= 1 && d <= LOWLEN + GAP);
    dn  = (d == LOWLEN + 1);
    if (d >= 1 && d <= LOWLEN) begin
      ncs = 1'b0;
      j = (d - 1) / CD;
      if (j < 32) begin
        copi_vld = 1'b1;
        if (j % 2 == 1) begin
          sclk = 1'b1;
          copi = f[15 - (j - 1) / 2];
        end else begin
          copi = f[15 - j / 2];
        end
      end
    end
  endfunction

  task automatic drive();
    if (acc0) begin void'(q0.pop_front()); req0_valid = 1'b0; acc0 = 0; end
    if (acc1) begin void'(q1.pop_front()); req1_valid = 1'b0; acc1 = 0; end
    if (!req0_valid && q0.size() > 0 && $urandom_range(99) < p0) begin
      req0_valid = 1'b1; {req0_addr, req0_data} = q0[0];
    end else if (!req0_valid) begin
      req0_addr = 7'($urandom); req0_data = 8'($urandom);
    end
    if (!req1_valid && q1.size() > 0 && $urandom_range(99) < p1) begin
      req1_valid = 1'b1; {req1_addr, req1_data} = q1[0];
    end else if (!req1_valid) begin
      req1_addr = 7'($urandom); req1_data = 8'($urandom);
    end
  endtask

  task automatic step();
    logic e_ncs, e_sclk, e_copi, e_cv, e_busy, e_done, e_r0, e_r1, m_sel, bad;
    logic [14:0] item;
    int d;
    @(posedge clk);
    cyc++;
    #1;
    d = m_active ? cyc - m_t0 : 1 << 20;
    exp_out(d, m_frame, e_ncs, e_sclk, e_copi, e_cv, e_busy, e_done);
    chk("nCS", nCS, e_ncs);
    chk("SCLK", SCLK, e_sclk);
    if (e_cv) chk("COPI", COPI, e_copi);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("grant_id", grant_id, m_grant);
    chk("err", err, cyc == m_err_at);
    if (SCLK && !sclk_prev) meas_bits = {meas_bits[14:0], COPI};
    if (!nCS) meas_low++;
    if (done) meas_done = cyc - meas_acc;
    sclk_prev = SCLK;
    drive();
    #1;
    m_sel = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    e_r0 = (cyc >= free_at) && (req0_valid || req1_valid) && !m_sel;
    e_r1 = (cyc >= free_at) && (req0_valid || req1_valid) && m_sel;
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    if (e_r0 || e_r1) begin
      item = m_sel ? q1[0] : q0[0];
      m_ptr = !m_sel;
      m_grant = m_sel;
`ifdef SPI_CFG_ADDR_CHECK_EN
      bad = (item[14:8] > 7'h04);
`else
      bad = 1'b0;
`endif
      if (bad) begin
        m_active = 0; m_err_at = cyc + 1; free_at = cyc + 1;
      end else begin
        m_active = 1; m_t0 = cyc; m_frame = {1'b1, item}; free_at = cyc + PERIOD;
      end
      acc_cyc.push_back(cyc);
      acc_id.push_back(m_sel);
      meas_acc = cyc; meas_low = 0; meas_bits = 16'h0000; meas_done = -1;
    end
    if (req0_valid && req0_ready) acc0 = 1;
    if (req1_valid && req1_ready) acc1 = 1;
  endtask

  task automatic run_until_idle(input string name, input int max_steps);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid || acc0 || acc1 || cyc < free_at)
           && n < max_steps) begin
      step();
      n++;
    end
    if (n >= max_steps) timeout_fail(name);
  endtask

  task automatic model_reset();
    m_active = 0; m_ptr = 0; m_grant = 0; m_err_at = -1; free_at = 0; sclk_prev = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_nCS"}, nCS, 1'b1);
    chk({tag, "_SCLK"}, SCLK, 1'b0);
    chk({tag, "_COPI"}, COPI, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_grant"}, grant_id, 1'b0);
    chk({tag, "_ready"}, {req0_ready, req1_ready}, 2'b00);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin @(posedge clk); cyc++; end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    // Reset state, with a valid request pending to show ready stays low.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single write 0x04/0xA5.
    q0.push_back({7'h04, 8'hA5});
    run_until_idle("single", 300);
    chk("single_bits", meas_bits, 16'h84A5);
    chk("single_ncs_low", meas_low, 132);
    chk("single_done_cycle", meas_done, 133);

    // Simultaneous requests after reset: req0 first, req1 137 cycles later.
    apply_reset();
    acc_cyc.delete(); acc_id.delete();
    q0.push_back({7'h00, 8'h0F});
    q1.push_back({7'h01, 8'hF0});
    run_until_idle("tie", 400);
    chk("tie_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) begin
      chk("tie_gap", acc_cyc[1] - acc_cyc[0], 137);
      chk("tie_first_id", acc_id[0], 1'b0);
      chk("tie_second_id", acc_id[1], 1'b1);
    end
    chk("tie_last_frame_bits", meas_bits, 16'h81F0);

    // Back-to-back writes from req1 alone.
    acc_cyc.delete(); acc_id.delete();
    for (int i = 0; i < 3; i++) q1.push_back({7'(i + 2), 8'(8'h11 * (i + 1))});
    run_until_idle("b2b", 600);
    chk("b2b_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap0", acc_cyc[1] - acc_cyc[0], 137);
      chk("b2b_gap1", acc_cyc[2] - acc_cyc[1], 137);
    end

    // Reset during bit 7, then a fresh write 0x02/0x3C.
    q0.push_back({7'h01, 8'h77});
    n = 0;
    while (!(m_active && cyc - m_t0 >= 70) && n < 300) begin step(); n++; end
    if (n >= 300) timeout_fail("midreset_wait");
    rst_n = 1'b0;
    model_reset();
    #1;
    reset_checks("midrst");
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    reset_checks("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    q0.push_back({7'h02, 8'h3C});
    run_until_idle("after_reset", 300);
    chk("after_reset_bits", meas_bits, 16'h823C);
    chk("after_reset_ncs_low", meas_low, 132);

`ifdef SPI_CFG_ADDR_CHECK_EN
    // Out-of-range address is accepted and dropped; the next write follows at once.
    acc_cyc.delete(); acc_id.delete();
    q0.push_back({7'h05, 8'h12});
    q0.push_back({7'h00, 8'h34});
    run_until_idle("addr_check", 300);
    chk("addr_check_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) chk("addr_check_gap", acc_cyc[1] - acc_cyc[0], 1);
    chk("addr_check_bits", meas_bits, 16'h8034);
`endif

    // Randomized traffic from both requesters with random valid timing.
    for (int i = 0; i < 30; i++) begin
      q0.push_back(15'($urandom));
      q1.push_back(15'($urandom));
    end
    p0 = 40; p1 = 60;
    run_until_idle("random", 20000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_cfg_controller.md
# spi_cfg_controller

SPI write-controller that drives the on-chip SPI configuration peripheral (16-bit write frames, registers 0x00–0x04: output enables, PWM enables, PWM duty cycle). It arbitrates round-robin between two internal requesters, each presenting an (address, data) write over a valid/ready handshake. It serializes each granted request as one mode-0 SPI frame on nCS/SCLK/COPI. It sits between the on-chip config sources (e.g. test sequencer, debug port) and the SPI peripheral's input pins.

## Interface
- CLK_DIV, 4, system clocks per SCLK half-period; legal ≥ 2 (peripheral uses 2-flop synchronizers); smaller values are an elaboration error
- CS_GAP, 4, system clocks nCS is held high between frames; legal ≥ 2
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req0_valid / req1_valid  input  1  requester has a pending write
- req0_ready / req1_ready  output  1  request accepted this cycle when valid&&ready
- req0_addr / req1_addr  input  7  target register address
- req0_data / req1_data  input  8  register write data
- nCS  output  1  SPI chip select, active-low
- SCLK  output  1  SPI clock, idle low
- COPI  output  1  SPI serial data, MSB first
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse: frame completed
- grant_id  output  1  requester owning the current/last transaction
- err  output  1  one-cycle pulse: request dropped (see Configuration)

## Operation
- Frame = {1'b1 (write), addr[6:0], data[7:0]}; bit 15 first.
- FSM states and transitions:
  - IDLE: if any valid, grant per arbiter and go to SETUP.
  - SETUP: nCS=0, SCLK=0, COPI=bit15; lasts CLK_DIV cycles, then HIGH.
  - HIGH: SCLK=1, COPI stable; lasts CLK_DIV cycles. After bit 0 go to HOLD, else to LOW.
  - LOW: SCLK=0, COPI=next bit from the first LOW cycle; lasts CLK_DIV cycles, then HIGH.
  - HOLD: SCLK=0, nCS=0; lasts CLK_DIV cycles, then GAP.
  - GAP: nCS=1; lasts CS_GAP cycles, then IDLE.
- Arbiter: 1-bit priority pointer, reset favors req0. With only one valid, that requester wins. With both valid, the pointer's requester wins. After any grant, the pointer favors the other requester.
- Handshake: reqN_ready is combinational, high only in IDLE for the requester the arbiter selects. addr/data are latched in the accept cycle. Requesters hold addr/data stable while valid && !ready. Valid without ready is never dropped.
- busy is high from the cycle after accept through the last GAP cycle. No request is accepted while busy.
- done is high in the first GAP cycle only.
- grant_id updates on accept and holds until the next accept.
- Reset values: nCS=1, SCLK=0, COPI=0, busy=0, done=0, err=0, grant_id=0, ready=0 during reset, state IDLE, pointer→req0.
- Reset mid-frame: all outputs take reset values immediately and asynchronously. The partial frame is abandoned, not resumed. The peripheral discards it because the next frame's nCS fall clears its bit counter.

## Timing
- The handshake happens in the accept cycle, cycle 0.
- nCS falls in cycle 1.
- nCS stays low for 33·CLK_DIV cycles: SETUP + 16 HIGH + 15 LOW + HOLD.
- SCLK rising edges occur at cycles 1+CLK_DIV+2k·CLK_DIV, for k=0..15.
- COPI changes only while SCLK is low, at least CLK_DIV cycles before each rising edge.
- Back-to-back accept-to-accept period = 1 + 33·CLK_DIV + CS_GAP. With defaults this is 137 cycles, and done falls in cycle 133.

## Configuration
- SPI_CFG_ADDR_CHECK_EN defined:
  - A request with addr > 7'h04 is accepted normally.
  - No frame is sent, busy stays 0, and done is not pulsed.
  - err pulses in the cycle after accept, and the FSM remains in IDLE.
  - The arbiter pointer still advances.
- SPI_CFG_ADDR_CHECK_EN undefined: all addresses are serialized, and err is tied 0.

## Test plan
- req0 writes addr 0x04, data 0xA5 → the 16 bits sampled on SCLK rises equal 0x84A5. nCS is low for 132 cycles, and done pulses at cycle 133. An attached SPI peripheral then shows pwm_duty_cycle=0xA5.
- req0 and req1 valid in the same cycle after reset (0x00/0x0F, 0x01/0xF0) → req0 is served first and req1 next. The gap between the two accepts is exactly 137 cycles, and grant_id reads 0 then 1.
- Back-to-back: req1 issues 3 writes while req0 is idle → all 3 frames are sent, accept-to-accept is 137 cycles each, and nCS is high ≥ 4 cycles between frames.
- Assert rst_n low at bit 7 of a frame, release, then write 0x02/0x3C → nCS=1 and SCLK=0 during reset. The new frame is received intact with en_reg_pwm_7_0=0x3C, and the previous register values are unchanged.
- With SPI_CFG_ADDR_CHECK_EN, req0 writes addr 0x05 → ready/valid handshake completes, err pulses 1 cycle, and there is no nCS activity. A following valid write to 0x00 proceeds normally.
- Hold req1_valid with ready low while a req0 frame runs → req1's data is sent unchanged after req0's GAP. No duplicate or lost frames.
